// File: rtl/kcc_pkg.sv
// Shared defaults and reference helpers for the tkeep <-> byte-count converter.
// Helpers work on the widest supported lane (16 bytes); callers cast to their width.
package kcc_pkg;

   localparam int KCC_KEEP_W    = 8;
   localparam int KCC_CNT_W     = 4;
   localparam int KCC_MAX_W     = 16;
   localparam int KCC_MAX_CNT_W = 5;

   function automatic logic [KCC_MAX_CNT_W-1:0] popcnt(input logic [KCC_MAX_W-1:0] keep);
      logic [KCC_MAX_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < KCC_MAX_W; i++) begin
         n = n + KCC_MAX_CNT_W'(keep[i]);
      end
      return n;
   endfunction

   // Upper cnt bytes of a keep_w-byte lane; counts beyond keep_w saturate to all ones.
   function automatic logic [KCC_MAX_W-1:0] left_mask(input logic [KCC_MAX_CNT_W-1:0] cnt,
                                                      input int keep_w);
      logic [KCC_MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < KCC_MAX_W; i++) begin
         if ((i < keep_w) && (i >= keep_w - int'(cnt))) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/kcc_popcount.sv
// Combinational pairwise adder tree counting the set bits of a tkeep mask.
module kcc_popcount
   import kcc_pkg::*;
#(
   parameter int KEEP_W = KCC_KEEP_W,
   parameter int CNT_W  = KCC_CNT_W
) (
   input  logic [KEEP_W-1:0] keep_i,
   output logic [CNT_W-1:0]  cnt_o
);

   // Each pass halves the number of partial sums; KEEP_W is a power of two.
   function automatic logic [CNT_W-1:0] tree_sum(input logic [KEEP_W-1:0] keep);
      logic [CNT_W-1:0] s [KEEP_W];
      for (int i = 0; i < KEEP_W; i++) begin
         s[i] = CNT_W'(keep[i]);
      end
      for (int w = KEEP_W / 2; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            s[i] = s[2*i] + s[2*i+1];
         end
      end
      return s[0];
   endfunction

   always_comb begin
      cnt_o = tree_sum(keep_i);
   end

endmodule

// File: rtl/keep_cnt_conv.sv
// tkeep -> byte count and byte count -> left-aligned tkeep, one registered stage.
// Optional build macro KCC_CHECK_EN adds keep_err, flagging non-contiguous tkeep masks.
module keep_cnt_conv
   import kcc_pkg::*;
#(
   parameter int KEEP_W = KCC_KEEP_W,
   parameter int CNT_W  = KCC_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [KEEP_W-1:0] keep_in,
   input  logic [CNT_W-1:0]  cnt_in,
   output logic              out_valid,
   output logic [CNT_W-1:0]  cnt_out,
   output logic [KEEP_W-1:0] keep_out
`ifdef KCC_CHECK_EN
   ,
   output logic              keep_err
`endif
);

   // Handshake: in_valid qualifies keep_in/cnt_in every cycle with no ready; out_valid is
   // in_valid delayed one cycle, and data outputs hold their last value while it is low.

   logic              out_valid_q, out_valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [KEEP_W-1:0] keep_q, keep_d;
   logic [CNT_W-1:0]  pop_cnt;

   kcc_popcount #(
      .KEEP_W (KEEP_W),
      .CNT_W  (CNT_W)
   ) u_popcount (
      .keep_i (keep_in),
      .cnt_o  (pop_cnt)
   );

   always_comb begin
      out_valid_d = in_valid;
      cnt_d       = cnt_q;
      keep_d      = keep_q;
      if (in_valid) begin
         cnt_d  = pop_cnt;
         keep_d = KEEP_W'(left_mask(KCC_MAX_CNT_W'(cnt_in), KEEP_W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         keep_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         keep_q      <= keep_d;
      end
   end

   assign out_valid = out_valid_q;
   assign cnt_out   = cnt_q;
   assign keep_out  = keep_q;

`ifdef KCC_CHECK_EN
   logic keep_err_q, keep_err_d;
   logic keep_bad;

   // Legal masks are 2^n-1: adding one clears every set bit. Zero passes too.
   always_comb begin
      keep_bad   = (keep_in & (keep_in + KEEP_W'(1))) != '0;
      keep_err_d = keep_err_q;
      if (in_valid) begin
         keep_err_d = keep_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         keep_err_q <= 1'b0;
      end else begin
         keep_err_q <= keep_err_d;
      end
   end

   assign keep_err = keep_err_q;
`endif

endmodule

// File: tb/tb_keep_cnt_conv.sv
// Directed self-checking bench for keep_cnt_conv (8-byte lane), with or without KCC_CHECK_EN.
module tb_keep_cnt_conv;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] keep_in;
   logic [3:0] cnt_in;
   logic       out_valid;
   logic [3:0] cnt_out;
   logic [7:0] keep_out;
`ifdef KCC_CHECK_EN
   logic       keep_err;
`endif

   int errors = 0;
   int checks = 0;

   keep_cnt_conv #(
      .KEEP_W (8),
      .CNT_W  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .keep_in   (keep_in),
      .cnt_in    (cnt_in),
      .out_valid (out_valid),
      .cnt_out   (cnt_out),
      .keep_out  (keep_out)
`ifdef KCC_CHECK_EN
      ,
      .keep_err  (keep_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are changed 1 time unit after the rising edge and outputs sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ones(input logic [7:0] k);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (k[i]) n = n + 4'd1;
      end
      return n;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         keep_in  = 8'($urandom_range(0, 255));
         cnt_in   = 4'($urandom_range(0, 15));
         step();
         checks++;
         if (out_valid !== 1'b0 || cnt_out !== 4'd0 || keep_out !== 8'h00) begin
            errors++;
            $display("FAIL reset cyc%0d: valid=%b cnt=%0d keep=%h, want 0/0/00",
                     c, out_valid, cnt_out, keep_out);
         end
      end
      rst      = 1'b0;
      in_valid = 1'b1;
      keep_in  = 8'hFF;
      cnt_in   = 4'd8;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || cnt_out !== 4'd8 || keep_out !== 8'hFF) begin
         errors++;
         $display("FAIL first_after_reset: valid=%b cnt=%0d keep=%h, want 1/8/FF",
                  out_valid, cnt_out, keep_out);
      end
   endtask

   task automatic test_midstream_reset();
      in_valid = 1'b1;
      keep_in  = 8'h0F;
      cnt_in   = 4'd4;
      step();
      rst     = 1'b1;
      keep_in = 8'h07;
      cnt_in  = 4'd2;
      step();
      checks++;
      if (out_valid !== 1'b0 || cnt_out !== 4'd0 || keep_out !== 8'h00) begin
         errors++;
         $display("FAIL midstream_reset: valid=%b cnt=%0d keep=%h, want 0/0/00",
                  out_valid, cnt_out, keep_out);
      end
      rst = 1'b0;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || cnt_out !== 4'd3 || keep_out !== 8'hC0) begin
         errors++;
         $display("FAIL after_midstream_reset: valid=%b cnt=%0d keep=%h, want 1/3/C0",
                  out_valid, cnt_out, keep_out);
      end
   endtask

   task automatic test_popcount();
      logic [3:0] want;
      cnt_in   = 4'd0;
      in_valid = 1'b1;
      for (int k = 0; k < 256; k++) begin
         keep_in = 8'(k);
         step();
         want = ones(8'(k));
         checks++;
         if (out_valid !== 1'b1 || cnt_out !== want || keep_out !== 8'h00) begin
            errors++;
            $display("FAIL popcount keep=%h: valid=%b cnt=%0d keep_out=%h, want 1/%0d/00",
                     k[7:0], out_valid, cnt_out, keep_out, want);
         end
      end
      // Spot values worked out by hand.
      keep_in = 8'hA5;
      step();
      checks++;
      if (cnt_out !== 4'd4) begin
         errors++;
         $display("FAIL popcount_A5: cnt=%0d, want 4", cnt_out);
      end
      keep_in = 8'h7F;
      step();
      checks++;
      if (cnt_out !== 4'd7) begin
         errors++;
         $display("FAIL popcount_7F: cnt=%0d, want 7", cnt_out);
      end
      keep_in = 8'h01;
      step();
      in_valid = 1'b0;
      checks++;
      if (cnt_out !== 4'd1) begin
         errors++;
         $display("FAIL popcount_01: cnt=%0d, want 1", cnt_out);
      end
   endtask

   task automatic test_left_mask();
      logic [7:0] exp_tbl [16];
      exp_tbl = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      keep_in  = 8'h00;
      in_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         cnt_in = 4'(c);
         step();
         checks++;
         if (out_valid !== 1'b1 || keep_out !== exp_tbl[c] || cnt_out !== 4'd0) begin
            errors++;
            $display("FAIL left_mask cnt=%0d: valid=%b keep_out=%h cnt_out=%0d, want 1/%h/0",
                     c, out_valid, keep_out, cnt_out, exp_tbl[c]);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] k_tbl [4];
      logic [3:0] c_tbl [4];
      logic [3:0] ec_tbl [4];
      logic [7:0] ek_tbl [4];
      k_tbl  = '{8'h03, 8'hF7, 8'h80, 8'h55};
      c_tbl  = '{4'd1,  4'd5,  4'd15, 4'd2};
      ec_tbl = '{4'd2,  4'd7,  4'd1,  4'd4};
      ek_tbl = '{8'h80, 8'hF8, 8'hFF, 8'hC0};
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         keep_in = k_tbl[i];
         cnt_in  = c_tbl[i];
         step();
         checks++;
         if (out_valid !== 1'b1 || cnt_out !== ec_tbl[i] || keep_out !== ek_tbl[i]) begin
            errors++;
            $display("FAIL b2b beat%0d: valid=%b cnt=%0d keep=%h, want 1/%0d/%h",
                     i, out_valid, cnt_out, keep_out, ec_tbl[i], ek_tbl[i]);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         keep_in = 8'h0F;
         cnt_in  = 4'd7;
         step();
         checks++;
         if (out_valid !== 1'b0 || cnt_out !== 4'd4 || keep_out !== 8'hC0) begin
            errors++;
            $display("FAIL idle_hold cyc%0d: valid=%b cnt=%0d keep=%h, want 0/4/C0",
                     i, out_valid, cnt_out, keep_out);
         end
      end
   endtask

`ifdef KCC_CHECK_EN
   task automatic test_keep_err();
      logic [7:0] k_tbl [6];
      logic       v_tbl [6];
      logic       e_tbl [6];
      k_tbl = '{8'h0F, 8'h00, 8'h0B, 8'hF0, 8'h0F, 8'h3F};
      v_tbl = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
      e_tbl = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
      cnt_in = 4'd0;
      for (int i = 0; i < 6; i++) begin
         keep_in  = k_tbl[i];
         in_valid = v_tbl[i];
         step();
         checks++;
         if (keep_err !== e_tbl[i]) begin
            errors++;
            $display("FAIL keep_err keep=%h vld=%b: err=%b, want %b",
                     k_tbl[i], v_tbl[i], keep_err, e_tbl[i]);
         end
      end
      keep_in  = 8'h05;
      in_valid = 1'b1;
      step();
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      checks++;
      if (keep_err !== 1'b0) begin
         errors++;
         $display("FAIL keep_err_reset: err=%b, want 0", keep_err);
      end
   endtask
`endif

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      keep_in  = 8'h00;
      cnt_in   = 4'd0;
      test_reset();
      test_midstream_reset();
      test_popcount();
      test_left_mask();
      test_back_to_back();
`ifdef KCC_CHECK_EN
      test_keep_err();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
